// File: rtl/sram_rd_pkg.sv
// rtl/sram_rd_pkg.sv - shared types and constants for the SRAM read streamer
package sram_rd_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 256;
    localparam int LEN_W      = 8;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/sram_rd_skid_fifo.sv
// rtl/sram_rd_skid_fifo.sv - 2-entry FIFO with registered head, {data, last} payload
module sram_rd_skid_fifo #(
    parameter int DATA_W = sram_rd_pkg::DATA_W
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               s_tvalid,
    input  logic [DATA_W-1:0]                  s_tdata,
    input  logic                               s_tlast,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [DATA_W-1:0]                  m_tdata,
    output logic                               m_tlast,
    output logic [sram_rd_pkg::FIFO_CNT_W-1:0] count
);
    import sram_rd_pkg::*;

    localparam logic [FIFO_CNT_W-1:0] CNT_FULL = FIFO_CNT_W'(FIFO_DEPTH);

    logic [DATA_W:0]         head_q, head_d;
    logic [DATA_W:0]         tail_q, tail_d;
    logic [FIFO_CNT_W-1:0]   count_q, count_d;
    logic                    pop;
    logic [DATA_W:0]         in_word;

    assign in_word  = {s_tlast, s_tdata};
    assign m_tvalid = (count_q != '0);
    assign m_tdata  = head_q[DATA_W-1:0];
    assign m_tlast  = head_q[DATA_W];
    assign count    = count_q;
    assign pop      = m_tvalid & m_tready;

    // Entry 0 is always the head; a pop shifts the tail forward.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({s_tvalid, pop})
            2'b10: begin
                if (count_q == '0) begin
                    head_d  = in_word;
                    count_d = count_q + 1'b1;
                end else if (count_q != CNT_FULL) begin
                    tail_d  = in_word;
                    count_d = count_q + 1'b1;
                end
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 1'b1;
            end
            2'b11: begin
                if (count_q == FIFO_CNT_W'(1)) begin
                    head_d = in_word;
                end else begin
                    head_d = tail_q;
                    tail_d = in_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(s_tvalid && !pop && count_q == CNT_FULL));

endmodule

// File: rtl/sram_rd_streamer.sv
// rtl/sram_rd_streamer.sv - burst reader for 1R1W SRAM; SRAM_RD_PERF_EN adds perf counters
module sram_rd_streamer #(
    parameter int ADDR_W = sram_rd_pkg::ADDR_W,
    parameter int DATA_W = sram_rd_pkg::DATA_W,
    parameter int LEN_W  = sram_rd_pkg::LEN_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              sram_R0_en,
    output logic [ADDR_W-1:0] sram_R0_addr,
    input  logic [DATA_W-1:0] sram_R0_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
`ifdef SRAM_RD_PERF_EN
    output logic [31:0]       perf_bursts,
    output logic [31:0]       perf_stalls,
`endif
    output logic              busy
);
    import sram_rd_pkg::*;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]      beats_left_q, beats_left_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;

    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  pop;
    logic                  issue;
    logic                  req_fire;
    logic [2:0]            occupancy;

    assign pop          = resp_valid & resp_ready;
    assign sram_R0_en   = issue;
    assign sram_R0_addr = cur_addr_q;
    assign req_fire     = req_valid & req_ready;
    assign busy         = (state_q == BURST) | inflight_q | (fifo_count != '0);

    // Credit: a beat may issue only if it will have a FIFO slot when it lands.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        beats_left_d    = beats_left_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        req_ready       = 1'b0;
        issue           = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cur_addr_d   = req_addr;
                    beats_left_d = req_len;
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (occupancy < 3'd2) begin
                    issue           = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_last_d = (beats_left_q == '0);
                    cur_addr_d      = cur_addr_q + ADDR_W'(1);
                    beats_left_d    = beats_left_q - LEN_W'(1);
                    if (beats_left_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cur_addr_q      <= '0;
            beats_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            beats_left_q    <= beats_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    sram_rd_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .s_tvalid (inflight_q),
        .s_tdata  (sram_R0_data),
        .s_tlast  (inflight_last_q),
        .m_tvalid (resp_valid),
        .m_tready (resp_ready),
        .m_tdata  (resp_data),
        .m_tlast  (resp_last),
        .count    (fifo_count)
    );

`ifdef SRAM_RD_PERF_EN
    logic [31:0] perf_bursts_q, perf_bursts_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_bursts_d = perf_bursts_q;
        perf_stalls_d = perf_stalls_q;
        if (req_fire && perf_bursts_q != '1) begin
            perf_bursts_d = perf_bursts_q + 32'd1;
        end
        if (state_q == BURST && !issue && perf_stalls_q != '1) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_bursts_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_bursts_q <= perf_bursts_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_bursts = perf_bursts_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_sram_rd_streamer.sv
// tb/tb_sram_rd_streamer.sv - randomized self-checking bench for sram_rd_streamer
module tb_sram_rd_streamer;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [7:0]   req_addr = '0;
    logic [7:0]   req_len = '0;
    logic         sram_R0_en;
    logic [7:0]   sram_R0_addr;
    logic [255:0] sram_R0_data = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [255:0] resp_data;
    logic         resp_last;
    logic         busy;
`ifdef SRAM_RD_PERF_EN
    logic [31:0]  perf_bursts;
    logic [31:0]  perf_stalls;
`endif

    sram_rd_streamer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .sram_R0_en   (sram_R0_en),
        .sram_R0_addr (sram_R0_addr),
        .sram_R0_data (sram_R0_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_last    (resp_last),
`ifdef SRAM_RD_PERF_EN
        .perf_bursts  (perf_bursts),
        .perf_stalls  (perf_stalls),
`endif
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [255:0] mem [256];
    always @(posedge clock) begin
        if (sram_R0_en) sram_R0_data <= mem[sram_R0_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: every accepted request expands into its list of lines.
    typedef struct { logic [255:0] data; logic last; } beat_t;
    beat_t        exp_q[$];
    int           outstanding = 0;
    logic         stall_prev = 1'b0;
    logic [255:0] prev_data = '0;
    logic         in_burst = 1'b0;
    int           issues_left = 0;
    logic [7:0]   exp_addr = '0;
    int           hs_cyc = 0;
    int           n_en = 0, n_resp = 0;
    int           first_en_cyc = -1, first_valid_cyc = -1;
    int           first_pop_cyc = -1, last_pop_cyc = -1;
    logic [7:0]   first_en_addr = '0;
    int           stall_exp = 0, bursts_exp = 0;
    int           rr_mode = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            outstanding = 0;
            stall_prev  = 1'b0;
            in_burst    = 1'b0;
            stall_exp   = 0;
            bursts_exp  = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", resp_valid, 1);
                chk("hold_data", resp_data, prev_data);
            end
            if (in_burst && !sram_R0_en) stall_exp++;
            if (sram_R0_en) begin
                chk("en_in_burst", in_burst, 1);
                chk("issue_addr", sram_R0_addr, exp_addr);
                exp_addr = exp_addr + 8'd1;
                n_en++;
                if (n_en == 1) begin
                    first_en_cyc  = cyc;
                    first_en_addr = sram_R0_addr;
                end
                issues_left--;
                if (issues_left == 0) in_burst = 1'b0;
            end
            if (resp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_resp", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("resp_data", resp_data, e.data);
                    chk("resp_last", resp_last, e.last);
                end
                n_resp++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
            outstanding = outstanding + int'(sram_R0_en) - int'(resp_valid && resp_ready);
            chk("credit_le2", outstanding <= 2, 1);
            if (req_valid && req_ready) begin
                hs_cyc      = cyc;
                in_burst    = 1'b1;
                issues_left = int'(req_len) + 1;
                exp_addr    = req_addr;
                bursts_exp++;
                for (int i = 0; i <= int'(req_len); i++) begin
                    beat_t b;
                    b.data = mem[8'(int'(req_addr) + i)];
                    b.last = (i == int'(req_len));
                    exp_q.push_back(b);
                end
            end
            stall_prev = resp_valid && !resp_ready;
            prev_data  = resp_data;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (rr_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = 1'($urandom_range(0, 1));
                default: resp_ready = 1'b0;
            endcase
        end
    end

    task automatic clear_stats();
        n_en = 0; n_resp = 0;
        first_en_cyc = -1; first_valid_cyc = -1;
        first_pop_cyc = -1; last_pop_cyc = -1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] l);
        logic ok;
        ok = 1'b0;
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        if (!ok) chk("req_timeout", 0, 1);
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_done", ok, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_en"}, sram_R0_en, 0);
        chk({tag, "_addr"}, sram_R0_addr, 0);
        chk({tag, "_valid"}, resp_valid, 0);
        chk({tag, "_last"}, resp_last, 0);
        chk({tag, "_data"}, resp_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
        end
        #2;
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // single beat
        rr_mode = 0;
        clear_stats();
        send(8'h10, 8'd0);
        drain();
        chk("single_en_cycle", first_en_cyc - hs_cyc, 1);
        chk("single_en_addr", first_en_addr, 8'h10);
        chk("single_en_count", n_en, 1);
        chk("single_valid_cycle", first_valid_cyc - hs_cyc, 3);
        chk("single_resp_count", n_resp, 1);
        chk("single_busy_low", busy, 0);

        // full rate
        clear_stats();
        send(8'h00, 8'd7);
        begin
            int s0;
            s0 = stall_exp;
            drain();
            chk("full_stalls", stall_exp - s0, 0);
        end
        chk("full_count", n_resp, 8);
        chk("full_span", last_pop_cyc - first_pop_cyc, 7);

        // wrap-around
        clear_stats();
        send(8'hFE, 8'd3);
        drain();
        chk("wrap_count", n_resp, 4);

        // backpressure
        rr_mode = 1;
        clear_stats();
        send(8'($urandom), 8'd15);
        drain();
        chk("bp_count", n_resp, 16);

        // random bursts
        for (int k = 0; k < 6; k++) begin
            int l;
            l = $urandom_range(0, 15);
            clear_stats();
            send(8'($urandom), 8'(l));
            drain();
            chk("rand_count", n_resp, l + 1);
        end

        // reset mid-burst
        rr_mode = 0;
        clear_stats();
        send(8'h80, 8'd15);
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clock);
                #1;
                if (n_resp >= 4) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("midburst_reach", ok, 1);
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        clear_stats();
        send(8'h40, 8'd1);
        drain();
        repeat (5) @(posedge clock);
        #1;
        chk("post_rst_count", n_resp, 2);

`ifdef SRAM_RD_PERF_EN
        pulse_reset();
        chk("perf_rst_bursts", perf_bursts, 0);
        chk("perf_rst_stalls", perf_stalls, 0);
        send(8'h20, 8'd7);
        drain();
        send(8'h30, 8'd15);
        rr_mode = 2;
        repeat (10) @(posedge clock);
        #1;
        rr_mode = 0;
        drain();
        send(8'h50, 8'd3);
        drain();
        chk("perf_bursts", perf_bursts, bursts_exp);
        chk("perf_bursts3", perf_bursts, 3);
        chk("perf_stalls", perf_stalls, stall_exp);
        chk("perf_stalls_min", perf_stalls >= 32'd8, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_rd_streamer.md
Name: sram_rd_streamer

Overview:
- Read-side client for the 1R1W masked-write SRAM macros (256 x 256b, two 128b lanes).
- Accepts burst read requests over a valid/ready interface and drives the SRAM read port.
- Absorbs the macro's one-cycle read latency and buffers returned lines in a 2-entry FIFO, so downstream backpressure is honoured without losing data.
- Sustains 1 line/cycle when the consumer is always ready.

Parameters:
ADDR_W, 8, SRAM address width; depth = 2^ADDR_W
DATA_W, 256, SRAM line width
LEN_W, 8, burst length field width (beats minus one)

Ports:
clock  in  1  single clock, also drives the SRAM read port
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  burst request valid
req_ready  out  1  burst request accepted when valid and ready are both high
req_addr  in  ADDR_W  first line address
req_len  in  LEN_W  beats minus one (0 means 1 beat)
sram_R0_en  out  1  SRAM read enable
sram_R0_addr  out  ADDR_W  SRAM read address
sram_R0_data  in  DATA_W  SRAM read data, valid the cycle after sram_R0_en
resp_valid  out  1  response line valid
resp_ready  in  1  consumer ready
resp_data  out  DATA_W  line data
resp_last  out  1  final beat of the burst
busy  out  1  state is BURST, or any beat is in flight, or FIFO is non-empty

Behaviour:
- Reset values: req_ready=1, sram_R0_en=0, sram_R0_addr=0, resp_valid=0, resp_last=0, resp_data=0, busy=0. Reset clears the FSM, counters, in-flight flag and FIFO.
- Reset asserted mid-burst discards in-flight and buffered beats. The SRAM contents are untouched.
- FSM states are IDLE and BURST.
  - IDLE: req_ready=1. A handshake latches req_addr into cur_addr, latches req_len into beats_left, and moves to BURST.
  - BURST: req_ready=0.
- Read issue, in BURST only:
  - sram_R0_en = (count + inflight - pop) < 2, where pop = resp_valid & resp_ready.
  - sram_R0_addr = cur_addr.
  - On issue: cur_addr increments modulo 2^ADDR_W (255 wraps to 0); beats_left decrements.
  - Issuing with beats_left == 0 marks that beat as last and returns the FSM to IDLE.
- inflight is a registered flag: 1 in the cycle after an issue, together with the last tag.
- Capture: when inflight=1, sram_R0_data and the last tag are pushed into the FIFO at the clock edge that ends that cycle.
- FIFO: 2 entries, registered head.
  - resp_valid = count != 0; resp_data and resp_last come from the head.
  - Push and pop in the same cycle are legal at any count.
  - Overflow is impossible by the credit rule. A push with count=2 and no pop is an assertion failure.
- Latency: request handshake at cycle T -> first sram_R0_en at T+1 -> FIFO push at the end of T+2 -> resp_valid at T+3.
- Throughput: with resp_ready held at 1, one beat per cycle. Back-to-back bursts have a one-cycle bubble, because req_ready is only high in IDLE.
- resp_ready=0: issue stops once count + inflight reaches 2. Data is held stable while resp_valid=1 and resp_ready=0.
- The block performs no read/write collision handling. The caller guarantees no writes to lines in an active burst.

Optional Feature:
SRAM_RD_PERF_EN
- Defined: adds outputs perf_bursts (32b, count of accepted requests) and perf_stalls (32b, cycles in BURST with sram_R0_en=0).
  - Both counters saturate at all-ones.
  - Both reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package sram_rd_pkg:
  - FSM state enum (IDLE, BURST).
  - Constants FIFO_DEPTH=2, FIFO_CNT_W=2.
  - Default widths ADDR_W, DATA_W, LEN_W.
- One sub-module, sram_rd_skid_fifo: 2-entry FIFO with {data, last} payload and count output. The issue/credit logic stays in the top.

Test Plan:
- Single beat: after reset, request addr=0x10, len=0; SRAM line 0x10 preloaded with pattern A.
  - sram_R0_en is high for exactly one cycle at T+1 with addr 0x10.
  - resp_valid, resp_last=1 and resp_data=A at T+3.
  - busy falls to 0 after the pop.
- Full-rate burst: addr=0x00, len=7, resp_ready=1.
  - Eight consecutive responses, lines 0..7, one per cycle.
  - resp_last only on the 8th.
  - Zero stall cycles.
- Wrap-around: addr=0xFE, len=3.
  - Responses are lines 0xFE, 0xFF, 0x00, 0x01, in order.
- Backpressure: len=15 with resp_ready toggled at random (about 50%).
  - All 16 lines are delivered in order, with no loss or duplication.
  - count + inflight never exceeds 2.
  - resp_data is stable while stalled.
- Reset mid-burst: assert reset_n=0 during beat 5 of a len=15 burst.
  - Outputs return to their reset values immediately.
  - A new request addr=0x40, len=1 afterwards returns only lines 0x40 and 0x41.
- With SRAM_RD_PERF_EN defined: three bursts, with resp_ready=0 for 10 cycles during the second.
  - perf_bursts=3 at the end.
  - perf_stalls equals the count of BURST-state cycles with sram_R0_en=0 (at least 8 during the 10-cycle stall).
